// File: rtl/fetch_pc.sv
// Program counter and instruction-fetch request stage. It sources pc+4 for the
// PC-select mux, runs the imem req/gnt/rvalid handshake and presents each fetched word to decode.
//
// state | meaning
// IDLE  | parked, no request outstanding
// REQ   | imem_req asserted at pc, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented to decode (inst_valid)
module fetch_pc #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            redirect,
   input  logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] seq_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t            r_state, w_state_nxt;
   logic [XLEN-1:0]   r_pc, w_pc_nxt;
   logic              r_kill, w_kill_nxt;
   logic              w_capture;
   logic [XLEN-1:0]   r_inst_pc, r_inst_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC[XLEN-1:0];
         r_kill      <= 1'b0;
         r_inst_pc   <= '0;
         r_inst_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
         if (w_capture) begin
            r_inst_pc   <= r_pc;
            r_inst_data <= imem_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_capture   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (redirect) w_pc_nxt = next_pc;
            if (en) w_state_nxt = REQ;
         end
         REQ: begin
            if (redirect) w_pc_nxt = next_pc;
            if (imem_gnt) begin
               w_state_nxt = WAIT;
               // A redirect on the grant cycle orphans the granted fetch.
               if (redirect) w_kill_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (redirect) begin
               w_pc_nxt = next_pc;
               if (imem_rvalid) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = REQ;
               end else begin
                  w_kill_nxt = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (r_kill) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               w_pc_nxt    = next_pc;
               w_state_nxt = REQ;
            end else if (inst_ready) begin
               w_pc_nxt    = next_pc;
               w_state_nxt = en ? REQ : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign seq_pc     = r_pc + XLEN'(4);
   assign imem_req   = (r_state == REQ);
   assign imem_addr  = r_pc;
   assign inst_valid = (r_state == HOLD);
   assign inst_pc    = r_inst_pc;
   assign inst_data  = r_inst_data;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: models the external PC-select mux and a simple
// instruction memory whose word is derived from the granted address.
module tb_fetch_pc;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, redirect = 1'b0;
   logic [31:0] tgt = '0;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0;
   logic [31:0] next_pc, seq_pc, imem_addr, inst_pc, inst_data, imem_rdata;
   logic        imem_req, inst_valid;
   logic [31:0] w_next_pc, w_seq_pc, w_imem_addr, w_inst_pc, w_inst_data;
   logic        w_imem_req, w_inst_valid;
   logic [31:0] mem_addr = '0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign next_pc    = redirect ? tgt : seq_pc;
   assign w_next_pc  = redirect ? tgt : w_seq_pc;
   assign imem_rdata = mem_addr ^ K;

   always @(posedge clk) if (imem_req && imem_gnt) mem_addr <= imem_addr;

   fetch_pc #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .en(en), .redirect(redirect), .next_pc(next_pc),
      .seq_pc(seq_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
      .inst_data(inst_data));

   fetch_pc #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .redirect(redirect), .next_pc(w_next_pc),
      .seq_pc(w_seq_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst_pc(w_inst_pc),
      .inst_data(w_inst_data));

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; redirect = 1'b0; tgt = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({imem_req, inst_valid, imem_addr, inst_pc, inst_data, seq_pc} !==
          {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4}) begin
         errors++;
         $display("FAIL reset_state req=%0b vld=%0b addr=%h ipc=%h idata=%h seq=%h",
                  imem_req, inst_valid, imem_addr, inst_pc, inst_data, seq_pc);
      end
   endtask

   task automatic test_stream();
      int last = 0, nvld = 0;
      logic [31:0] exp_pc = 32'h0;
      do_reset();
      en = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         if (inst_valid) begin
            checks++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ K) || n !== last + 3) begin
               errors++;
               $display("FAIL stream pc=%h data=%h cyc=%0d want pc=%h data=%h cyc=%0d",
                        inst_pc, inst_data, n, exp_pc, exp_pc ^ K, last + 3);
            end
            last = n; nvld++; exp_pc += 32'd4;
         end
      end
      checks++;
      if (nvld !== 3) begin
         errors++;
         $display("FAIL stream_count got %0d want 3", nvld);
      end
   endtask

   task automatic test_gnt_stall();
      do_reset();
      redirect = 1'b1; tgt = 32'h10;
      step();
      redirect = 1'b0; en = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL gnt_stall req=%0b addr=%h want 1 00000010", imem_req, imem_addr);
         end
         step();
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL gnt_to_wait req=%0b vld=%0b want 0 0", imem_req, inst_valid);
      end
      imem_rvalid = 1'b1;
      step();
      imem_rvalid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_data !== (32'h10 ^ K)) begin
         errors++;
         $display("FAIL gnt_hold vld=%0b pc=%h data=%h want 1 00000010 %h",
                  inst_valid, inst_pc, inst_data, 32'h10 ^ K);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
         errors++;
         $display("FAIL gnt_next req=%0b addr=%h want 1 00000014", imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      int seen = 0;
      do_reset();
      redirect = 1'b1; tgt = 32'h8;
      step();
      redirect = 1'b0; en = 1'b1; imem_gnt = 1'b1;
      step();
      step();
      imem_gnt = 1'b0; redirect = 1'b1; tgt = 32'h100;
      step();
      redirect = 1'b0;
      if (inst_valid) seen++;
      for (int i = 0; i < 2; i++) begin
         step();
         if (inst_valid) seen++;
      end
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL kill_wait req=%0b want 0", imem_req);
      end
      imem_rvalid = 1'b1;
      step();
      imem_rvalid = 1'b0;
      if (inst_valid) seen++;
      checks++;
      if (seen !== 0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL kill_drop vld_cycles=%0d req=%0b addr=%h want 0 1 00000100",
                  seen, imem_req, imem_addr);
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1;
      step();
      imem_rvalid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== (32'h100 ^ K)) begin
         errors++;
         $display("FAIL kill_refetch vld=%0b pc=%h data=%h want 1 00000100 %h",
                  inst_valid, inst_pc, inst_data, 32'h100 ^ K);
      end
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      en = 1'b1; imem_gnt = 1'b1;
      step();
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; redirect = 1'b1; tgt = 32'h200;
      step();
      redirect = 1'b0; imem_rvalid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++;
         $display("FAIL redir_rvalid vld=%0b req=%0b addr=%h want 0 1 00000200",
                  inst_valid, imem_req, imem_addr);
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1;
      step();
      imem_rvalid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
         errors++;
         $display("FAIL redir_rvalid_nokill vld=%0b pc=%h want 1 00000200", inst_valid, inst_pc);
      end
   endtask

   task automatic test_hold_stall();
      do_reset();
      en = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1;
      step();
      step();
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== K || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable vld=%0b pc=%h data=%h req=%0b want 1 00000000 %h 0",
                     inst_valid, inst_pc, inst_data, imem_req, K);
         end
         step();
      end
      redirect = 1'b1; tgt = 32'h40; inst_ready = 1'b1;
      step();
      redirect = 1'b0; inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL hold_redirect vld=%0b req=%0b addr=%h want 0 1 00000040",
                  inst_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_en_low();
      do_reset();
      en = 1'b1;
      step();
      en = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
      step();
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL en_low_complete vld=%0b pc=%h want 1 00000000", inst_valid, inst_pc);
      end
      step();
      step();
      step();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL en_low_park req=%0b vld=%0b addr=%h want 0 0 00000004",
                  imem_req, inst_valid, imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++;
      if (w_seq_pc !== 32'h0 || w_imem_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_seq seq=%h addr=%h want 00000000 fffffffc", w_seq_pc, w_imem_addr);
      end
      en = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
      step();
      step();
      step();
      checks++;
      if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_first vld=%0b pc=%h want 1 fffffffc", w_inst_valid, w_inst_pc);
      end
      step();
      checks++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_second req=%0b addr=%h want 1 00000000", w_imem_req, w_imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      redirect = 1'b1; tgt = 32'h20;
      step();
      redirect = 1'b0; en = 1'b1; imem_gnt = 1'b1;
      step();
      step();
      #2 rst = 1'b1; imem_rvalid = 1'b1;
      #1;
      checks++;
      if ({imem_req, inst_valid, imem_addr, inst_pc, inst_data} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_async req=%0b vld=%0b addr=%h ipc=%h idata=%h want all 0",
                  imem_req, inst_valid, imem_addr, inst_pc, inst_data);
      end
      step();
      step();
      rst = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_rvalid vld=%0b req=%0b want 0 0", inst_valid, imem_req);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_refetch req=%0b addr=%h vld=%0b want 1 00000000 0",
                  imem_req, imem_addr, inst_valid);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_gnt_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_hold_stall();
      test_en_low();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
